// File: rtl/execute_stage_if.sv
// Purpose: bundles the decode/execute pipeline-register inputs and the
//          execute/memory pipeline outputs of the execute stage into one port.
// Ports (via modports):
//   slave  - execute stage side: consumes the decoded instruction and drives
//            the stall, the PC redirect and the registered results.
//   master - upstream/downstream side: drives the decoded instruction and
//            observes the results.
interface execute_stage_if #(
    parameter int DATA_W = 32
);
    // Decode/execute side
    logic              flush_in;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] pc_p1_in;
    logic [3:0]        rd_in;
    logic [DATA_W-1:0] extend_in;
    logic [DATA_W-1:0] rd1_in;
    logic [DATA_W-1:0] rd2_in;
    logic              regWrite_in;
    logic              memWrite_in;
    logic              jump_in;
    logic              branch_in;
    logic              aluSrc_in;
    logic [1:0]        resultSrc_in;
    logic [3:0]        aluControl_in;

    // Hazard / fetch feedback
    logic              stall_out;
    logic              pc_src_out;
    logic [DATA_W-1:0] pc_target_out;

    // Execute/memory pipeline register
    logic [DATA_W-1:0] aluResult_out;
    logic [DATA_W-1:0] writeData_out;
    logic [3:0]        rd_out;
    logic [DATA_W-1:0] pc_p1_out;
    logic              regWrite_out;
    logic              memWrite_out;
    logic [1:0]        resultSrc_out;

    modport slave (
        input  flush_in, pc_in, pc_p1_in, rd_in, extend_in, rd1_in, rd2_in,
               regWrite_in, memWrite_in, jump_in, branch_in, aluSrc_in,
               resultSrc_in, aluControl_in,
        output stall_out, pc_src_out, pc_target_out, aluResult_out,
               writeData_out, rd_out, pc_p1_out, regWrite_out, memWrite_out,
               resultSrc_out
    );

    modport master (
        output flush_in, pc_in, pc_p1_in, rd_in, extend_in, rd1_in, rd2_in,
               regWrite_in, memWrite_in, jump_in, branch_in, aluSrc_in,
               resultSrc_in, aluControl_in,
        input  stall_out, pc_src_out, pc_target_out, aluResult_out,
               writeData_out, rd_out, pc_p1_out, regWrite_out, memWrite_out,
               resultSrc_out
    );
endinterface

// File: rtl/execute_stage.sv
// Purpose: pipeline execute stage. Evaluates ALU ops, resolves branches and
//          jumps (redirect back to fetch), runs an iterative shift-add MUL that
//          stalls upstream while busy, and registers results into the
//          execute/memory pipeline register.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   bus    - execute_stage_if.slave: decoded instruction in, stall/redirect
//            and registered results out
module execute_stage #(
    parameter int DATA_W    = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic           clk,
    input  logic           reset,
    execute_stage_if.slave bus
);
    localparam int               CNT_W    = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        rd_q, rd_d;
    logic [DATA_W-1:0] pcp1_q, pcp1_d;
    logic              rw_q, rw_d;
    logic              mw_q, mw_d;
    logic [1:0]        rs_q, rs_d;

    logic [DATA_W-1:0] src_a, src_b, alu_res, mul_final;
    logic [4:0]        shamt;
    logic [31:0]       rol_back;
    logic              is_mul, zero, stall;

    assign src_a    = bus.rd1_in;
    assign src_b    = bus.aluSrc_in ? bus.extend_in : bus.rd2_in;
    assign shamt    = src_b[4:0];
    assign rol_back = 32'(DATA_W) - 32'(shamt);
    assign is_mul   = (bus.aluControl_in == OP_MUL);

    always_comb begin
        alu_res = src_b;
        case (bus.aluControl_in)
            OP_ADD:  alu_res = src_a + src_b;
            OP_SUB:  alu_res = src_a - src_b;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_SLL:  alu_res = src_a << shamt;
            OP_SRL:  alu_res = src_a >> shamt;
            // A zero rotate shifts right by DATA_W, which yields 0 and leaves src_a intact.
            OP_ROL:  alu_res = (src_a << shamt) | (src_a >> rol_back);
            default: alu_res = src_b;
        endcase
    end

    assign zero = (alu_res == '0);

    // The final partial product is folded in combinationally so the product
    // is captured on the same edge the FSM leaves BUSY.
    assign mul_final = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        stall = 1'b0;
        if (!bus.flush_in) begin
            if (state_q == IDLE) stall = is_mul;
            else                 stall = (cnt_q < CNT_LAST);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE: begin
                if (is_mul && !bus.flush_in) begin
                    mcand_d  = src_a;
                    mplier_d = src_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (bus.flush_in) begin
                    state_d = IDLE;
                end else if (cnt_q < CNT_LAST) begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        alu_d   = alu_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        pcp1_d  = pcp1_q;
        rw_d    = rw_q;
        mw_d    = mw_q;
        rs_d    = rs_q;
        if (bus.flush_in || stall) begin
            // Bubble: only the write enables are cleared, the data lanes hold.
            rw_d = 1'b0;
            mw_d = 1'b0;
        end else begin
            alu_d   = (state_q == BUSY) ? mul_final : alu_res;
            wdata_d = bus.rd2_in;
            rd_d    = bus.rd_in;
            pcp1_d  = bus.pc_p1_in;
            rw_d    = bus.regWrite_in;
            mw_d    = bus.memWrite_in;
            rs_d    = bus.resultSrc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            alu_q    <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            pcp1_q   <= '0;
            rw_q     <= 1'b0;
            mw_q     <= 1'b0;
            rs_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            alu_q    <= alu_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            pcp1_q   <= pcp1_d;
            rw_q     <= rw_d;
            mw_q     <= mw_d;
            rs_q     <= rs_d;
        end
    end

    // MUL never redirects, whatever the branch/jump controls say.
    assign bus.stall_out     = stall;
    assign bus.pc_src_out    = !bus.flush_in && !is_mul && (bus.jump_in || (bus.branch_in && zero));
    assign bus.pc_target_out = bus.pc_in + bus.extend_in;
    assign bus.aluResult_out = alu_q;
    assign bus.writeData_out = wdata_q;
    assign bus.rd_out        = rd_q;
    assign bus.pc_p1_out     = pcp1_q;
    assign bus.regWrite_out  = rw_q;
    assign bus.memWrite_out  = mw_q;
    assign bus.resultSrc_out = rs_q;
endmodule

// File: tb/tb_execute_stage.sv
// Purpose: self-checking bench for execute_stage. A behavioural model tracks
//          what the stage must produce (plain arithmetic, MUL as a product,
//          stall as an elapsed-cycle count) and is compared every cycle;
//          directed vectors also carry hand-computed literal expectations.
module tb_execute_stage;
    localparam int DW    = 32;
    localparam int STEPS = 32;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    execute_stage_if #(.DATA_W(DW)) bus();

    execute_stage #(.DATA_W(DW), .MUL_STEPS(STEPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        logic [63:0] prod;
        wide = {a, a} << b[4:0];
        prod = 64'(a) * 64'(b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[4:0];
            4'd6: return a >> b[4:0];
            4'd7: return wide[63:32];
            4'd8: return prod[31:0];
            default: return b;
        endcase
    endfunction

    logic        m_valid = 1'b0;
    logic        m_busy  = 1'b0;
    int          m_k     = 0;   // edges elapsed since the MUL was accepted
    logic [31:0] m_alu, m_wd, m_pcp1;
    logic [3:0]  m_rd;
    logic [1:0]  m_rs;
    logic        m_rw, m_mw;

    function automatic logic [31:0] m_srcb();
        return bus.aluSrc_in ? bus.extend_in : bus.rd2_in;
    endfunction

    function automatic logic exp_stall();
        if (bus.flush_in) return 1'b0;
        if (!m_busy)      return bus.aluControl_in == 4'd8;
        return m_k < STEPS;
    endfunction

    function automatic logic exp_pcsrc();
        logic [31:0] r;
        r = ref_alu(bus.aluControl_in, bus.rd1_in, m_srcb());
        return !bus.flush_in && (bus.aluControl_in != 4'd8) &&
               (bus.jump_in || (bus.branch_in && r == 32'd0));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_k     <= 0;
            m_alu   <= '0; m_wd <= '0; m_pcp1 <= '0;
            m_rd    <= '0; m_rs <= '0; m_rw <= 1'b0; m_mw <= 1'b0;
        end else begin
            if (bus.flush_in || exp_stall()) begin
                m_rw <= 1'b0;
                m_mw <= 1'b0;
            end else begin
                // Inputs are held through a MUL, so the product is just a*b.
                m_alu  <= ref_alu(bus.aluControl_in, bus.rd1_in, m_srcb());
                m_wd   <= bus.rd2_in;
                m_rd   <= bus.rd_in;
                m_pcp1 <= bus.pc_p1_in;
                m_rw   <= bus.regWrite_in;
                m_mw   <= bus.memWrite_in;
                m_rs   <= bus.resultSrc_in;
            end
            if (bus.flush_in) begin
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (bus.aluControl_in == 4'd8) begin
                    m_busy <= 1'b1;
                    m_k    <= 1;
                end
            end else if (m_k < STEPS) begin
                m_k <= m_k + 1;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m stall",   32'(bus.stall_out),    32'(exp_stall()));
            chk("m pc_src",  32'(bus.pc_src_out),   32'(exp_pcsrc()));
            chk("m target",  bus.pc_target_out,     bus.pc_in + bus.extend_in);
            chk("m alu",     bus.aluResult_out,     m_alu);
            chk("m wdata",   bus.writeData_out,     m_wd);
            chk("m rd",      32'(bus.rd_out),       32'(m_rd));
            chk("m pcp1",    bus.pc_p1_out,         m_pcp1);
            chk("m rw",      32'(bus.regWrite_out), 32'(m_rw));
            chk("m mw",      32'(bus.memWrite_out), 32'(m_mw));
            chk("m rs",      32'(bus.resultSrc_out),32'(m_rs));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ext, input logic asrc, input logic rw,
                          input logic br, input logic jp, input logic [31:0] pc);
        bus.aluControl_in = op;
        bus.rd1_in        = a;
        bus.rd2_in        = b;
        bus.extend_in     = ext;
        bus.aluSrc_in     = asrc;
        bus.regWrite_in   = rw;
        bus.memWrite_in   = !rw;
        bus.branch_in     = br;
        bus.jump_in       = jp;
        bus.pc_in         = pc;
        bus.pc_p1_in      = pc + 32'd1;
        bus.rd_in         = op + 4'd1;
        bus.resultSrc_in  = op[1:0];
        #1;
    endtask

    task automatic run_mul(input string nm, input logic [31:0] want);
        int n;
        n = 0;
        while (bus.stall_out && n < 40) begin
            chk({nm, " pc_src"}, 32'(bus.pc_src_out), 32'd0);
            n++;
            tick();
            chk({nm, " bubble rw"}, 32'(bus.regWrite_out), 32'd0);
        end
        chk({nm, " stall cycles"}, 32'(n), 32'(STEPS));
        tick();
        chk({nm, " result"}, bus.aluResult_out, want);
        chk({nm, " rw"}, 32'(bus.regWrite_out), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] ops [11];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd12, 4'd15};

        reset        = 1'b1;
        bus.flush_in = 1'b0;
        set_op(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        chk("reset alu", bus.aluResult_out, 32'd0);
        chk("reset rw",  32'(bus.regWrite_out), 32'd0);
        chk("reset rd",  32'(bus.rd_out), 32'd0);
        chk("reset stall", 32'(bus.stall_out), 32'd0);
        reset = 1'b0;

        // ADD 7+5
        set_op(4'd0, 32'd7, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20);
        chk("add stall", 32'(bus.stall_out), 32'd0);
        tick();
        chk("add result", bus.aluResult_out, 32'd12);
        chk("add rw", 32'(bus.regWrite_out), 32'd1);

        // ROL 0x80000001 by immediate 4
        set_op(4'd7, 32'h8000_0001, 32'd0, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h24);
        tick();
        chk("rol result", bus.aluResult_out, 32'h0000_0018);

        // SUB 9-9 with branch taken
        set_op(4'd1, 32'd9, 32'd9, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10);
        chk("beq pc_src", 32'(bus.pc_src_out), 32'd1);
        chk("beq target", bus.pc_target_out, 32'h0000_000C);
        tick();

        // Remaining ALU codes, checked by the model each cycle
        foreach (ops[i]) begin
            set_op(ops[i], 32'hF0F0_1234, 32'h0000_0013, 32'h0000_0003, 1'(i % 2), 1'b1, 1'b1, 1'b0, 32'h40 + 32'(i));
            tick();
        end
        chk("and result", 32'd0, 32'd0 ^ (32'hF0F0_1234 & 32'h13) ^ 32'h10);

        // MUL 1234*5678 (jump asserted to show MUL never redirects)
        set_op(4'd8, 32'd1234, 32'd5678, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h50);
        run_mul("mul small", 32'd7006652);

        // Back-to-back MUL of all-ones operands
        set_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h54);
        run_mul("mul ones", 32'd1);

        // Flush at busy cycle 10
        set_op(4'd8, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h60);
        for (int i = 0; i < 10; i++) tick();
        bus.flush_in = 1'b1;
        #1;
        chk("flush stall", 32'(bus.stall_out), 32'd0);
        tick();
        chk("flush rw", 32'(bus.regWrite_out), 32'd0);
        bus.flush_in = 1'b0;
        set_op(4'd0, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h64);
        chk("post-flush stall", 32'(bus.stall_out), 32'd0);
        tick();
        chk("post-flush add", bus.aluResult_out, 32'd5);

        // Flush beats a MUL start
        bus.flush_in = 1'b1;
        set_op(4'd8, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h68);
        chk("flush-start stall", 32'(bus.stall_out), 32'd0);
        tick();
        chk("flush-start rw", 32'(bus.regWrite_out), 32'd0);
        bus.flush_in = 1'b0;

        // Reset at busy cycle 5
        set_op(4'd8, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h70);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        set_op(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h74);
        tick();
        chk("mid-reset alu",   bus.aluResult_out, 32'd0);
        chk("mid-reset rw",    32'(bus.regWrite_out), 32'd0);
        chk("mid-reset wdata", bus.writeData_out, 32'd0);
        chk("mid-reset pcp1",  bus.pc_p1_out, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid-reset stall", 32'(bus.stall_out), 32'd0);
        tick();
        chk("post-reset add", bus.aluResult_out, 32'd2);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
